// File: rtl/jesd_rx_cgs.sv
// jesd_rx_cgs: JESD204B receive code-group synchronization (CS_INIT/CS_CHECK/CS_DATA), drives SYNC~.
module jesd_rx_cgs #(
  parameter int K_COUNT    = 4,
  parameter int ERR_LIMIT  = 3,
  parameter int GOOD_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       kin,
  input  logic       code_err,
  input  logic       disp_err,
  input  logic       din_valid,
  input  logic       sync_req,
  output logic       sync_n,
  output logic [1:0] cgs_state,
  output logic [7:0] dout,
  output logic       kout,
  output logic       dout_valid,
  output logic       char_err,
  output logic       ilas_start
);
  typedef enum logic [1:0] {CS_INIT = 2'b00, CS_CHECK = 2'b01, CS_DATA = 2'b10} state_t;
  state_t state, state_nx;
  logic [3:0] kcnt, kcnt_nx;
  logic [1:0] err_cnt, err_nx;
  logic [2:0] good_cnt, good_nx;
  logic armed, armed_nx, ilas_nx;
  logic kchar, inval, good;
  assign kchar = din_valid & kin & (din == 8'hBC) & ~code_err & ~disp_err;
  assign inval = din_valid & (code_err | disp_err);
  assign good = din_valid & ~code_err & ~disp_err;
  assign cgs_state = state;
  always_comb begin
    state_nx = state;
    kcnt_nx = kcnt;
    err_nx = err_cnt;
    good_nx = good_cnt;
    armed_nx = armed;
    ilas_nx = 1'b0;
    if (sync_req) begin
      state_nx = CS_INIT;
      kcnt_nx = '0;
      err_nx = '0;
      good_nx = '0;
      armed_nx = 1'b0;
    end else if (din_valid) begin
      if (state == CS_INIT) begin
        kcnt_nx = kchar ? kcnt + 4'd1 : '0;
        if (kchar && kcnt == 4'(K_COUNT - 1)) begin
          state_nx = CS_DATA;
          kcnt_nx = '0;
          armed_nx = 1'b1;
        end
      end else begin
        // first valid character that is not K28.5 marks the ILAS start
        if (armed && good && !kchar) begin
          ilas_nx = 1'b1;
          armed_nx = 1'b0;
        end
        if (state == CS_DATA) begin
          if (inval) begin
            state_nx = CS_CHECK;
            err_nx = 2'd1;
            good_nx = '0;
          end
        end else if (inval) begin
          err_nx = err_cnt + 2'd1;
          good_nx = '0;
          if ({1'b0, err_cnt} + 3'd1 == 3'(ERR_LIMIT)) begin
            state_nx = CS_INIT;
            kcnt_nx = '0;
            err_nx = '0;
            armed_nx = 1'b0;
          end
        end else if (good_cnt + 3'd1 == 3'(GOOD_COUNT)) begin
          good_nx = '0;
          err_nx = err_cnt - 2'd1;
          state_nx = (err_cnt == 2'd1) ? CS_DATA : CS_CHECK;
        end else begin
          good_nx = good_cnt + 3'd1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CS_INIT;
      kcnt <= '0;
      err_cnt <= '0;
      good_cnt <= '0;
      armed <= 1'b0;
      sync_n <= 1'b0;
      dout <= '0;
      kout <= 1'b0;
      dout_valid <= 1'b0;
      char_err <= 1'b0;
      ilas_start <= 1'b0;
    end else begin
      state <= state_nx;
      kcnt <= kcnt_nx;
      err_cnt <= err_nx;
      good_cnt <= good_nx;
      armed <= armed_nx;
      sync_n <= (state_nx != CS_INIT);
      dout <= din;
      kout <= kin;
      dout_valid <= din_valid & (state != CS_INIT);
      char_err <= inval;
      ilas_start <= ilas_nx;
    end
  end
endmodule

// File: tb/tb_jesd_rx_cgs.sv
// tb_jesd_rx_cgs: directed plus randomized checks of jesd_rx_cgs against a lane-level reference model.
module tb_jesd_rx_cgs;
  localparam int K_COUNT = 4, ERR_LIMIT = 3, GOOD_COUNT = 4;
  logic clk = 0, reset = 1;
  logic [7:0] din = 0;
  logic kin = 0, code_err = 0, disp_err = 0, din_valid = 0, sync_req = 0;
  logic sync_n, dout_valid, kout, char_err, ilas_start;
  logic [1:0] cgs_state;
  logic [7:0] dout;
  int n_tests = 0, n_fail = 0;
  int krun, errs, goods;
  bit synced, armed;
  int e_dout, e_kout, e_cerr, e_dv, e_ilas;
  jesd_rx_cgs #(.K_COUNT(K_COUNT), .ERR_LIMIT(ERR_LIMIT), .GOOD_COUNT(GOOD_COUNT)) dut (
    .clk(clk), .reset(reset), .din(din), .kin(kin), .code_err(code_err), .disp_err(disp_err),
    .din_valid(din_valid), .sync_req(sync_req), .sync_n(sync_n), .cgs_state(cgs_state),
    .dout(dout), .kout(kout), .dout_valid(dout_valid), .char_err(char_err), .ilas_start(ilas_start)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_clear();
    krun = 0; errs = 0; goods = 0; synced = 0; armed = 0;
  endtask
  // Link view: not synced -> CS_INIT; synced with outstanding errors -> CS_CHECK; else CS_DATA.
  task automatic model_step(input logic [7:0] d, input bit k, input bit ce, input bit de, input bit v, input bit sr);
    bit bad, isk;
    bad = ce | de;
    isk = k && d == 8'hBC && !bad;
    e_dout = d; e_kout = k; e_cerr = v & bad; e_dv = v & synced; e_ilas = 0;
    if (sr) model_clear();
    else if (v) begin
      if (!synced) begin
        krun = isk ? krun + 1 : 0;
        if (krun == K_COUNT) begin synced = 1; armed = 1; krun = 0; end
      end else begin
        if (!bad && !isk && armed) begin e_ilas = 1; armed = 0; end
        if (bad) begin
          errs++; goods = 0;
          if (errs >= ERR_LIMIT) begin synced = 0; errs = 0; armed = 0; end
        end else if (errs > 0) begin
          goods++;
          if (goods == GOOD_COUNT) begin goods = 0; errs--; end
        end
      end
    end
  endtask
  task automatic check_all(input string ph);
    chk({ph, ".state"}, cgs_state, !synced ? 0 : (errs > 0 ? 1 : 2));
    chk({ph, ".sync_n"}, sync_n, synced);
    chk({ph, ".dout"}, dout, e_dout);
    chk({ph, ".kout"}, kout, e_kout);
    chk({ph, ".dout_valid"}, dout_valid, e_dv);
    chk({ph, ".char_err"}, char_err, e_cerr);
    chk({ph, ".ilas_start"}, ilas_start, e_ilas);
  endtask
  task automatic cyc(input string ph, input logic [7:0] d, input bit k, input bit ce = 0, input bit de = 0,
                     input bit v = 1, input bit sr = 0);
    din = d; kin = k; code_err = ce; disp_err = de; din_valid = v; sync_req = sr;
    model_step(d, k, ce, de, v, sr);
    @(posedge clk); #1;
    check_all(ph);
  endtask
  task automatic do_reset(input string ph);
    reset = 1; din_valid = 0; sync_req = 0;
    model_clear();
    e_dout = 0; e_kout = 0; e_cerr = 0; e_dv = 0; e_ilas = 0;
    @(posedge clk); #1;
    check_all(ph);
    reset = 0;
  endtask
  task automatic bc(input string ph, input int n);
    for (int i = 0; i < n; i++) cyc(ph, 8'hBC, 1);
  endtask
  initial begin
    do_reset("rst");
    bc("tp1", 4);
    chk("tp1.sync_up", sync_n, 1);
    chk("tp1.data_state", cgs_state, 2);
    do_reset("rst2");
    bc("tp2", 3);
    cyc("tp2", 8'h1C, 1);
    bc("tp2", 3);
    chk("tp2.still_init", sync_n, 0);
    cyc("tp2", 8'hBC, 1);
    chk("tp2.sync_up", sync_n, 1);
    bc("tp3", 2);
    cyc("tp3", 8'h1C, 1);
    chk("tp3.ilas", ilas_start, 1);
    chk("tp3.ilas_dout", dout, 8'h1C);
    cyc("tp3", 8'h00, 0);
    chk("tp3.no_second", ilas_start, 0);
    cyc("tp4", 8'h55, 0, 1, 0);
    chk("tp4.check", cgs_state, 1);
    for (int i = 0; i < 4; i++) cyc("tp4", 8'(i), 0);
    chk("tp4.back", cgs_state, 2);
    for (int e = 0; e < 3; e++) begin
      cyc("tp5", 8'hAA, 0, 0, 1);
      if (e < 2) begin cyc("tp5", 8'h11, 0); cyc("tp5", 8'h22, 0); end
    end
    chk("tp5.init", cgs_state, 0);
    chk("tp5.sync_n", sync_n, 0);
    bc("tp6", 3);
    cyc("tp6", 8'hBC, 1, 0, 0, 1, 1);
    chk("tp6.sr_init", cgs_state, 0);
    bc("tp6", 4);
    cyc("tp6", 8'h00, 0, 1, 0);
    cyc("tp6", 8'h01, 0);
    cyc("tp6", 8'h02, 0, 0, 0, 1, 1);
    chk("tp6.sr_check", cgs_state, 0);
    bc("tp7", 2);
    cyc("tp7", 8'hBC, 1, 0, 0, 0);
    cyc("tp7", 8'h00, 0, 0, 0, 0);
    bc("tp7", 2);
    chk("tp7.gap", sync_n, 1);
    for (int i = 0; i < 4000; i++) begin
      int r;
      bit v, k, ce, de, sr;
      logic [7:0] d;
      r = $urandom_range(0, 99);
      v = $urandom_range(0, 9) != 0;
      sr = $urandom_range(0, 199) == 0;
      ce = $urandom_range(0, 29) == 0;
      de = $urandom_range(0, 29) == 0;
      k = r < 60 || r >= 95;
      d = r < 60 ? 8'hBC : (r >= 95 ? 8'h1C : 8'($urandom));
      if (i % 1500 == 1499) do_reset("rnd_rst");
      else cyc("rnd", d, k, ce, de, v, sr);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
